// File: rtl/bp_network_serializer_arbiter.sv
// Round-robin arbiter that grants one local requester at a time and serializes its
// message onto a single network link as {dest, src, payload} flits.
module bp_network_serializer_arbiter #(
  parameter int num_req_p           = 4,
  parameter int num_dest            = 4,
  parameter int num_src             = 8,
  parameter int src_id_offset_p     = 0,
  parameter int source_data_width_p = 64,
  parameter int packet_data_width_p = 16,
  localparam int dest_id_width_p    = (num_dest <= 1) ? 1 : $clog2(num_dest),
  localparam int src_id_width_p     = (num_src <= 1) ? 1 : $clog2(num_src),
  localparam int flit_width_lp      = packet_data_width_p + dest_id_width_p + src_id_width_p
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_req_p-1:0]                     v_i,
  input  logic [num_req_p*source_data_width_p-1:0] data_i,
  input  logic [num_req_p*dest_id_width_p-1:0]     dest_i,
  output logic [num_req_p-1:0]                     yumi_o,
  output logic                                     v_o,
  output logic [flit_width_lp-1:0]                 data_o,
  input  logic                                     ready_i
);

  localparam int num_packets_p = (source_data_width_p + packet_data_width_p - 1) / packet_data_width_p;
  localparam int cnt_w_lp      = (num_packets_p <= 1) ? 1 : $clog2(num_packets_p);
  localparam int req_w_lp      = (num_req_p <= 1) ? 1 : $clog2(num_req_p);
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(num_packets_p - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                           r_state;
  state_e                           w_state_next;
  logic [cnt_w_lp-1:0]              r_count;
  logic [req_w_lp-1:0]              r_last_grant;
  logic [source_data_width_p-1:0]   r_msg;
  logic [dest_id_width_p-1:0]       r_dest;
  logic [src_id_width_p-1:0]        r_src;

  logic [source_data_width_p-1:0]   w_req_data [num_req_p];
  logic [dest_id_width_p-1:0]       w_req_dest [num_req_p];
  logic [packet_data_width_p-1:0]   w_flits    [num_packets_p];
  logic [req_w_lp-1:0]              w_winner;
  logic                             w_any_v;
  logic                             w_handshake;
  logic                             w_last;
  logic                             w_capture_en;
  logic                             w_capture;

  genvar gi;
  generate
    for (gi = 0; gi < num_req_p; gi++) begin : g_req
      assign w_req_data[gi] = data_i[gi*source_data_width_p +: source_data_width_p];
      assign w_req_dest[gi] = dest_i[gi*dest_id_width_p +: dest_id_width_p];
    end

    // The final flit may only be partly covered by the message; its upper bits read as zero.
    for (gi = 0; gi < num_packets_p; gi++) begin : g_flit
      if ((gi + 1) * packet_data_width_p <= source_data_width_p) begin : g_full
        assign w_flits[gi] = r_msg[gi*packet_data_width_p +: packet_data_width_p];
      end else begin : g_pad
        assign w_flits[gi] = {{((gi + 1) * packet_data_width_p - source_data_width_p){1'b0}},
                              r_msg[source_data_width_p-1:gi*packet_data_width_p]};
      end
    end
  endgenerate

  // Scan from the farthest candidate to the nearest so the nearest requester after
  // the last grant is the one left standing.
  always_comb begin
    logic [req_w_lp:0] sum;
    sum      = '0;
    w_winner = '0;
    w_any_v  = 1'b0;
    for (int k = num_req_p; k >= 1; k--) begin
      sum = {1'b0, r_last_grant} + (req_w_lp + 1)'(k);
      if (sum >= (req_w_lp + 1)'(num_req_p)) begin
        sum = sum - (req_w_lp + 1)'(num_req_p);
      end
      if (v_i[sum[req_w_lp-1:0]]) begin
        w_winner = sum[req_w_lp-1:0];
        w_any_v  = 1'b1;
      end
    end
  end

  assign w_handshake  = (r_state == SEND) & ready_i;
  assign w_last       = (r_count == last_cnt_lp);
  assign w_capture_en = ~reset_i & ((r_state == IDLE) | (w_handshake & w_last));
  assign w_capture    = w_capture_en & w_any_v;

  always_comb begin
    w_state_next = r_state;
    yumi_o       = '0;
    v_o          = (r_state == SEND);
    if (w_capture) begin
      yumi_o[w_winner] = 1'b1;
      w_state_next     = SEND;
    end else if (w_capture_en) begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count      <= '0;
      r_last_grant <= req_w_lp'(num_req_p - 1);
    end else if (w_capture) begin
      r_count      <= '0;
      r_last_grant <= w_winner;
    end else if (w_handshake) begin
      r_count <= w_last ? '0 : r_count + cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_capture) begin
      r_msg  <= w_req_data[w_winner];
      r_dest <= w_req_dest[w_winner];
      r_src  <= src_id_width_p'(src_id_offset_p) + src_id_width_p'(w_winner);
    end
  end

  assign data_o = {r_dest, r_src, w_flits[r_count]};

endmodule

// File: doc/bp_network_serializer_arbiter.md
Name: bp_network_serializer_arbiter

Overview:
Shares one network injection link among num_req_p local requesters. Each requester offers a wide message plus destination ID. A round-robin scheduler grants one requester, captures its message, and serializes it into num_packets_p flits. Each flit is formatted {dest_id, src_id, payload_slice}, which is the flit format consumed by the per-source network deserializer at the far end. The block never interleaves flits of different messages on the link.

Parameters:
num_req_p, 4, number of local requesters sharing the link
num_dest, 4, number of destinations; dest_id_width_p = BSG_SAFE_CLOG2(num_dest)
num_src, 8, network-wide source count; src_id_width_p = BSG_SAFE_CLOG2(num_src)
src_id_offset_p, 0, src_id of requester i is src_id_offset_p+i; must satisfy src_id_offset_p+num_req_p <= num_src
source_data_width_p, 64, message width
packet_data_width_p, 16, payload bits per flit; num_packets_p = ceil(source_data_width_p/packet_data_width_p)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
v_i  in  num_req_p  per-requester message valid
data_i  in  num_req_p*source_data_width_p  messages; requester i occupies slice i
dest_i  in  num_req_p*dest_id_width_p  destination IDs; requester i occupies slice i
yumi_o  out  num_req_p  one-hot; requester's message captured this cycle
v_o  out  1  flit valid
data_o  out  packet_data_width_p+dest_id_width_p+src_id_width_p  flit {dest, src, payload}, with dest in the MSBs
ready_i  in  1  link accepts flit when v_o&ready_i

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high, on reset_i.
- Reset state:
  - State is IDLE; v_o=0; yumi_o=0; flit counter=0.
  - Round-robin last-grant pointer = num_req_p-1, so requester 0 has top priority.
  - Reset mid-message discards the captured message; no further flits of it are sent.
- States:
  - IDLE: v_o=0.
  - SEND: v_o=1 every cycle; data_o is stable until the handshake.
- Capture:
  - Capture is enabled in IDLE, and in SEND on the handshake cycle of the last flit (count==num_packets_p-1 & ready_i).
  - When enabled and |v_i, the winner is the first requester with v_i high, scanning from last_grant+1 upward with wrap.
  - Same cycle as capture: yumi_o[winner]=1 (combinational from v_i and state); message, dest, and src_id_offset_p+winner are registered; counter=0; state becomes SEND; last_grant updates to winner.
  - Enabled capture with no v_i high: go to / stay in IDLE.
  - yumi_o is never asserted for a requester whose v_i is low. At most one yumi_o bit is high per cycle.
- Serialization:
  - Flit k payload = message bits [k*packet_data_width_p +: packet_data_width_p], for k = 0..num_packets_p-1 in order.
  - Bits above source_data_width_p in the last flit are zero.
  - Counter increments only on v_o&ready_i and wraps to 0 after num_packets_p-1.
  - ready_i low holds the counter and data_o unchanged, for any number of stall cycles.
- Latency and throughput:
  - The first flit is valid the cycle after capture.
  - Back-to-back messages cause no idle cycle: after the last handshake, the next message's flit 0 appears the following cycle.
  - Peak throughput is one flit per cycle.
- num_packets_p==1: every handshake in SEND is a last-flit handshake and an eligible capture point.
- Requester inputs may change freely while not granted. data_i/dest_i are sampled only on the yumi cycle.

Test Plan:
- Single message: v_i=4'b0001, data_i[63:0]=64'h1111_2222_3333_4444, dest_i[0]=2, ready_i=1.
  -> yumi_o=0001 in cycle 0.
  -> Cycles 1-4 carry payloads 4444, 3333, 2222, 1111 with dest=2, src=0.
  -> v_o=0 in cycle 5.
- Round-robin fairness: v_i=4'b1111 held, ready_i=1.
  -> Grants go in order 0, 1, 2, 3, 0.
  -> Each message occupies exactly 4 consecutive flit cycles with no gaps; src field equals the grant index.
- Backpressure: single message with ready_i low for 3 cycles after flit 1 is presented.
  -> Flit 1 is held unchanged for 3 cycles; no flit is skipped or duplicated; yumi_o stays 0 for other requesters during the stall.
- Last-flit capture: requester 2 raises v_i during the last-flit stall of a requester 1 message.
  -> yumi_o[2]=1 exactly on the last-flit handshake cycle.
  -> Requester 2's flit 0 is presented the next cycle.
- Reset mid-message: assert reset_i after flit 1 of requester 3's message.
  -> v_o=0 next cycle; remaining flits are never sent.
  -> With v_i=4'b1001 after reset, requester 0 is granted first.
- Padding: source_data_width_p=40, packet_data_width_p=16, message=40'hAB_CDEF_0123.
  -> 3 flits: 0123, CDEF, 00AB.
